// File: rtl/vn_edge_ctrl.sv
// Edge controller for a stochastic LDPC variable node: init fill, agree/hold regeneration,
// random edge-memory addressing and a saturating hard-decision counter.
module vn_edge_ctrl #(
  parameter int unsigned N     = 8,
  parameter int unsigned NS    = 3,
  parameter logic [7:0]  SEED  = 8'hA5,
  parameter int unsigned DEC_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          en,
  input  logic          ch,
  input  logic          in1,
  input  logic          in2,
  input  logic          em_out,
  output logic          trig,
  output logic          push_bit,
  output logic [NS-1:0] sel,
  output logic          out,
  output logic          hold,
  output logic          dec,
  output logic          init_done
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic signed [DEC_W-1:0] DecMax = {1'b0, {(DEC_W-1){1'b1}}};
  localparam logic signed [DEC_W-1:0] DecMin = {1'b1, {(DEC_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            icnt_q, icnt_d;
  logic signed [DEC_W-1:0]  dcnt_q, dcnt_d;
  logic [7:0]               lfsr_q, lfsr_d;
  logic [NS-1:0]            sel_q, sel_d;
  logic                     out_q, out_d;
  logic                     hold_q, hold_d;
  logic                     push_q, push_d;
  logic                     trig_q, trig_d;
  logic                     dec_q, dec_d;
  logic                     done_q, done_d;

  // Folds an out-of-range LFSR slice back into the valid address range.
  function automatic logic [NS-1:0] mod_n(input logic [NS-1:0] v);
    logic [31:0] t;
    t = 32'(v) % 32'(N);
    return t[NS-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    dcnt_d  = dcnt_q;
    lfsr_d  = lfsr_q;
    out_d   = out_q;
    hold_d  = hold_q;
    push_d  = push_q;
    trig_d  = 1'b0;
    done_d  = done_q;

    if (start) begin
      state_d = StInit;
      icnt_d  = '0;
      dcnt_d  = '0;
      done_d  = 1'b0;
    end else if (en) begin
      unique case (state_q)
        StInit: begin
          push_d = ch;
          out_d  = ch;
          trig_d = 1'b1;
          hold_d = 1'b0;
          icnt_d = icnt_q + CW'(1);
          if (icnt_q == CW'(N - 1)) begin
            state_d = StRun;
            done_d  = 1'b1;
          end
        end
        StRun: begin
          if ((ch == in1) && (ch == in2)) begin
            out_d  = ch;
            push_d = ch;
            trig_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            out_d  = em_out;
            hold_d = 1'b1;
          end
          if (out_d) begin
            if (dcnt_q != DecMax) dcnt_d = dcnt_q + DEC_W'(1);
          end else begin
            if (dcnt_q != DecMin) dcnt_d = dcnt_q - DEC_W'(1);
          end
        end
        default: ;
      endcase
    end

    // The LFSR steps on every enabled cycle, regardless of state or start.
    if (en) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    sel_d = mod_n(lfsr_d[NS-1:0]);
    dec_d = !dcnt_d[DEC_W-1] && (dcnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      icnt_q  <= '0;
      dcnt_q  <= '0;
      lfsr_q  <= SEED;
      sel_q   <= mod_n(SEED[NS-1:0]);
      out_q   <= 1'b0;
      hold_q  <= 1'b0;
      push_q  <= 1'b0;
      trig_q  <= 1'b0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
      lfsr_q  <= lfsr_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      hold_q  <= hold_d;
      push_q  <= push_d;
      trig_q  <= trig_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  assign trig      = trig_q;
  assign push_bit  = push_q;
  assign sel       = sel_q;
  assign out       = out_q;
  assign hold      = hold_q;
  assign dec       = dec_q;
  assign init_done = done_q;

endmodule

// File: doc/vn_edge_ctrl.md
VN_EDGE_CTRL -- requirements
Module: vn_edge_ctrl

Interface
REQ-001 Parameter N, default 8; edge-memory depth, and the number of init pushes.
REQ-002 Parameter NS, default 3; select width, with N <= 2^NS.
REQ-003 Parameter SEED, default 8'hA5; LFSR reset value, nonzero.
REQ-004 Parameter DEC_W, default 4; signed decision-counter width.
REQ-005 CLK  in  1  single clock; all state updates on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 START  in  1  pulse; (re)starts the init phase.
REQ-008 EN  in  1  stochastic-cycle enable; when low, all state holds.
REQ-009 CH  in  1  channel stochastic bit.
REQ-010 IN1, IN2  in  1 each  incoming extrinsic edge bits.
REQ-011 EM_OUT  in  1  bit read from the downstream edge memory at address SEL.
REQ-012 TRIG  out  1  one-cycle push strobe to the edge memory.
REQ-013 PUSH_BIT  out  1  data bit for the edge memory shift input.
REQ-014 SEL  out  NS  random edge-memory read address.
REQ-015 OUT  out  1  regenerated edge output bit.
REQ-016 HOLD  out  1  high when the last enabled cycle was a hold.
REQ-017 DEC  out  1  hard decision.
REQ-018 INIT_DONE  out  1  high while in RUN.

Function
REQ-019 The block SHALL have three states: IDLE, INIT and RUN.
REQ-020 START=1 in any state SHALL enter INIT on the next edge, clear the init counter, and take priority over all other transitions.
REQ-021 In INIT, each EN=1 cycle SHALL set PUSH_BIT<=CH, OUT<=CH, TRIG<=1, HOLD<=0, and increment the init counter.
REQ-022 INIT SHALL move to RUN on the edge at which the N-th enabled push is issued; INIT_DONE SHALL rise on that same edge.
REQ-023 In RUN, an EN=1 cycle with CH==IN1==IN2 (agree) SHALL set OUT<=CH, PUSH_BIT<=CH, TRIG<=1 and HOLD<=0.
REQ-024 In RUN, an EN=1 cycle without agreement (hold) SHALL set OUT<=EM_OUT, TRIG<=0 and HOLD<=1; PUSH_BIT SHALL keep its value.
REQ-025 TRIG SHALL be registered and SHALL be high for exactly one cycle per push; it SHALL be 0 in any cycle following EN=0, and 0 in IDLE.
REQ-026 In IDLE, OUT, TRIG and HOLD SHALL stay 0, and EN SHALL be ignored except for LFSR stepping.
REQ-027 SEL SHALL be bits [NS-1:0] of an 8-bit Fibonacci LFSR with polynomial x^8+x^6+x^5+x^4+1.
- The LFSR SHALL step once per EN=1 cycle in every state.
- SEL SHALL be registered, with a 1-cycle latency from the step.
REQ-028 If SEL is >= N, the SEL output SHALL be reduced modulo N.
REQ-029 The decision counter SHALL update in RUN only, per EN=1 cycle, based on the new OUT value: +1 if OUT is 1, -1 if OUT is 0.
REQ-030 The decision counter SHALL saturate at +(2^(DEC_W-1)-1) and -(2^(DEC_W-1)); it SHALL never wrap.
REQ-031 DEC SHALL be registered and SHALL equal 1 exactly when the counter is > 0.
REQ-032 The decision counter SHALL clear to 0 on START.
REQ-033 EN=0 SHALL freeze the state, counters, LFSR, OUT, HOLD and PUSH_BIT, and SHALL force TRIG<=0.
REQ-034 START and EN both high in the same cycle SHALL enter INIT with the init counter at 0.
- That cycle's push SHALL NOT be counted.
- TRIG<=0 in that cycle.
REQ-035 EM_OUT SHALL be sampled in the same cycle as the hold decision; the address used is the SEL value presented during that cycle.

Reset
REQ-036 RESET=1 SHALL set the following, and SHALL override START and EN:
- state to IDLE;
- OUT, TRIG, HOLD, PUSH_BIT, DEC and INIT_DONE to 0;
- init and decision counters to 0;
- LFSR to SEED, with SEL=SEED[NS-1:0] mod N.
REQ-037 RESET asserted mid-INIT or mid-RUN SHALL abort at the next edge, with no TRIG pulse emitted after that edge.

Verification
REQ-038 Scenario: reset, then START, then EN=1 with CH=1 for 8 cycles -> 8 TRIG pulses with PUSH_BIT=1 and OUT=1; INIT_DONE rises with the 8th pulse.
REQ-039 Scenario: RUN, then CH=IN1=IN2=0 -> next cycle OUT=0, PUSH_BIT=0, TRIG=1, HOLD=0.
REQ-040 Scenario: RUN, then CH=1, IN1=0, IN2=1, EM_OUT=1 -> next cycle OUT=1, TRIG=0, HOLD=1, PUSH_BIT unchanged.
REQ-041 Scenario: 20 agree cycles with OUT=1 (DEC_W=4) -> counter saturates at +7, DEC=1; then 15 cycles with OUT=0 -> counter reaches -8 and holds, DEC=0.
REQ-042 Scenario: EN toggling 1,0,1 in RUN with agreement -> TRIG pattern 1,0,1; the LFSR steps twice; SEL sequence matches a reference LFSR started from SEED.
REQ-043 Scenario: RESET asserted on the 4th INIT push cycle -> TRIG=0 and state IDLE next cycle; a following START requires a full 8 pushes.
